// File: rtl/ext_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ext_pipe
// Description : Registered immediate / load-data extender with a 2-entry
//               skid FIFO, valid/ready on both sides and a sideband tag.
//               Optional macro EXT_MISALIGN_CHK_EN adds a misaligned
//               halfword flag carried with each stored beat.
// Revision    : 1.0 - initial release
// ============================================================================
module ext_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5,
    parameter int AL_W  = $clog2(OUT_W / 8)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [OUT_W-1:0] in_data,
    input  logic [AL_W-1:0]  in_addr,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_misalign
);

    localparam logic [1:0] c_full = 2'd2;

    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic [OUT_W-1:0] r_mem_data [2];
    logic [TAG_W-1:0] r_mem_tag  [2];

    logic             w_accept;
    logic             w_pop;
    logic [OUT_W-1:0] w_ext;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;

    // Handshake: ready depends only on registered occupancy
    assign in_ready  = (r_count != c_full);
    assign out_valid = (r_count != 2'd0);
    assign w_accept  = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    // Head entry is presented directly from storage
    assign out_data  = r_mem_data[r_rd_ptr];
    assign out_tag   = r_mem_tag[r_rd_ptr];

    // Byte / halfword lanes of the loaded word; halfword ignores addr[0]
    assign w_byte = in_data[{in_addr, 3'b000} +: 8];
    assign w_half = in_data[{in_addr[AL_W-1:1], 4'b0000} +: 16];

    // Extension is done before storage so the FIFO holds final results
    always_comb begin
        w_ext = '0;
        case (in_op)
            3'b000: w_ext = {{(OUT_W-IN_W){1'b0}}, in_imm};
            3'b001: w_ext = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
            3'b010: w_ext = {in_imm, {(OUT_W-IN_W){1'b0}}};
            3'b011: w_ext = {in_imm[IN_W-1], {(OUT_W-IN_W-1){1'b0}}, in_imm};
            3'b100: w_ext = {{(OUT_W-8){1'b0}}, w_byte};
            3'b101: w_ext = {{(OUT_W-8){w_byte[7]}}, w_byte};
            3'b110: w_ext = {{(OUT_W-16){1'b0}}, w_half};
            default: w_ext = {{(OUT_W-16){w_half[15]}}, w_half};
        endcase
    end

    // Storage entries change only when a beat is accepted (flush drops it)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                r_mem_data[i] <= '0;
                r_mem_tag[i]  <= '0;
            end
        end else if (w_accept && !flush) begin
            r_mem_data[r_wr_ptr] <= w_ext;
            r_mem_tag[r_wr_ptr]  <= in_tag;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the buffer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_accept) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)    r_rd_ptr <= ~r_rd_ptr;
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef EXT_MISALIGN_CHK_EN
    logic r_mem_mis [2];
    logic w_mis;

    // Halfword loads at an odd byte offset are flagged
    assign w_mis        = in_op[2] & in_op[1] & in_addr[0];
    assign out_misalign = r_mem_mis[r_rd_ptr];

    // Misalign flag travels with its beat through the same storage slot
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_mis[0] <= 1'b0;
            r_mem_mis[1] <= 1'b0;
        end else if (w_accept && !flush) begin
            r_mem_mis[r_wr_ptr] <= w_mis;
        end
    end
`else
    assign out_misalign = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ext_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_ext_pipe
// Description : Directed, table-driven self-checking bench for ext_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ext_pipe;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [15:0] in_imm;
    logic [31:0] in_data;
    logic [1:0]  in_addr;
    logic [4:0]  in_tag;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic        out_misalign;

`ifdef EXT_MISALIGN_CHK_EN
    localparam bit c_mis_en = 1'b1;
`else
    localparam bit c_mis_en = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] imm;
        logic [31:0] data;
        logic [1:0]  addr;
        logic [4:0]  tag;
        logic [31:0] exp;
        logic        mis;
    } vec_t;

    vec_t vecs [11];

    ext_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_imm       (in_imm),
        .in_data      (in_data),
        .in_addr      (in_addr),
        .in_tag       (in_tag),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_tag      (out_tag),
        .out_misalign (out_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] imm,
                         input logic [31:0] data, input logic [1:0] addr, input logic [4:0] tag);
        in_valid = v;
        in_op    = op;
        in_imm   = imm;
        in_data  = data;
        in_addr  = addr;
        in_tag   = tag;
    endtask

    initial begin
        vecs[0]  = '{3'b001, 16'h8001, 32'h0,        2'd0, 5'd3,  32'hFFFF8001, 1'b0};
        vecs[1]  = '{3'b000, 16'h8001, 32'h0,        2'd0, 5'd4,  32'h00008001, 1'b0};
        vecs[2]  = '{3'b010, 16'h8001, 32'h0,        2'd0, 5'd5,  32'h80010000, 1'b0};
        vecs[3]  = '{3'b011, 16'h8001, 32'h0,        2'd0, 5'd6,  32'h80008001, 1'b0};
        vecs[4]  = '{3'b101, 16'h0,    32'h80FF7F01, 2'd2, 5'd7,  32'hFFFFFFFF, 1'b0};
        vecs[5]  = '{3'b100, 16'h0,    32'h80FF7F01, 2'd3, 5'd8,  32'h00000080, 1'b0};
        vecs[6]  = '{3'b111, 16'h0,    32'h80FF7F01, 2'd2, 5'd9,  32'hFFFF80FF, 1'b0};
        vecs[7]  = '{3'b110, 16'h0,    32'h80FF7F01, 2'd0, 5'd10, 32'h00007F01, 1'b0};
        vecs[8]  = '{3'b111, 16'h0,    32'h80FF7F01, 2'd1, 5'd11, 32'h00007F01, 1'b1};
        vecs[9]  = '{3'b111, 16'h0,    32'h80FF7F01, 2'd3, 5'd12, 32'hFFFF80FF, 1'b1};
        vecs[10] = '{3'b101, 16'h0,    32'h80FF7F01, 2'd1, 5'd31, 32'h0000007F, 1'b0};

        reset_n   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 3'b000, 16'h0, 32'h0, 2'd0, 5'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // reset state
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
        chk("rst_out_data",  out_data,           32'd0);
        chk("rst_out_tag",   {27'b0, out_tag},   32'd0);
        chk("rst_misalign",  {31'b0, out_misalign}, 32'd0);

        // back-to-back table, one beat per cycle with out_ready high
        for (int i = 0; i <= 11; i++) begin
            if (i > 0) begin
                chk($sformatf("vec%0d_valid", i-1), {31'b0, out_valid}, 32'd1);
                chk($sformatf("vec%0d_data", i-1),  out_data, vecs[i-1].exp);
                chk($sformatf("vec%0d_tag", i-1),   {27'b0, out_tag}, {27'b0, vecs[i-1].tag});
                chk($sformatf("vec%0d_mis", i-1),   {31'b0, out_misalign},
                    {31'b0, vecs[i-1].mis & c_mis_en});
            end
            if (i < 11)
                drive(1'b1, vecs[i].op, vecs[i].imm, vecs[i].data, vecs[i].addr, vecs[i].tag);
            else
                in_valid = 1'b0;
            @(negedge clk);
        end
        chk("drain_valid", {31'b0, out_valid}, 32'd0);

        // backpressure: A,B fill the buffer, C is held
        out_ready = 1'b0;
        drive(1'b1, 3'b000, 16'h00AA, 32'h0, 2'd0, 5'd1);
        @(negedge clk);
        chk("bp_ready_c1", {31'b0, in_ready}, 32'd1);
        chk("bp_head_a",   out_data, 32'h000000AA);
        drive(1'b1, 3'b000, 16'h00BB, 32'h0, 2'd0, 5'd2);
        @(negedge clk);
        chk("bp_ready_full", {31'b0, in_ready}, 32'd0);
        drive(1'b1, 3'b000, 16'h00CC, 32'h0, 2'd0, 5'd3);
        @(negedge clk);
        chk("bp_ready_held", {31'b0, in_ready}, 32'd0);
        chk("bp_stable_a",   out_data, 32'h000000AA);
        chk("bp_stable_tag", {27'b0, out_tag}, 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_pop_b",     out_data, 32'h000000BB);
        chk("bp_ready_one", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_pop_c",     out_data, 32'h000000CC);
        chk("bp_pop_c_tag", {27'b0, out_tag}, 32'd3);
        chk("bp_valid_c",   {31'b0, out_valid}, 32'd1);
        @(negedge clk);
        chk("bp_empty", {31'b0, out_valid}, 32'd0);

        // flush at count 2 while a beat is offered
        out_ready = 1'b0;
        drive(1'b1, 3'b001, 16'h1111, 32'h0, 2'd0, 5'd4);
        @(negedge clk);
        drive(1'b1, 3'b001, 16'h2222, 32'h0, 2'd0, 5'd5);
        @(negedge clk);
        chk("fl_full", {31'b0, in_ready}, 32'd0);
        drive(1'b1, 3'b001, 16'h3333, 32'h0, 2'd0, 5'd6);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", {31'b0, out_valid}, 32'd0);
        chk("fl_ready", {31'b0, in_ready},  32'd1);
        @(negedge clk);
        chk("fl_absent", {31'b0, out_valid}, 32'd0);

        // asynchronous reset pulse at count 1
        drive(1'b1, 3'b000, 16'h5A5A, 32'h0, 2'd0, 5'd9);
        @(negedge clk);
        in_valid = 1'b0;
        chk("rp_valid_before", {31'b0, out_valid}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rp_valid_async", {31'b0, out_valid}, 32'd0);
        chk("rp_data_async",  out_data, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rp_no_beat", {31'b0, out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
